sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO, the next generation of the team's basic single-clock FIFO.
- Adds concurrent read and write on the same cycle, a read-valid strobe, an occupancy count and programmable almost-full/almost-empty thresholds.
- Optionally adds sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in one clock domain.

Parameters:
- DEPTH, 16, entry count; power of two, >= 2.
- WIDTH, 8, data width in bits; >= 1.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- asrst, input, 1, reset; asynchronous, active-high.
- wren, input, 1, write request.
- wrdata, input, WIDTH, write data.
- full, output, 1, count == DEPTH.
- almost_full, output, 1, count >= AF_LEVEL.
- rden, input, 1, read request.
- rddata, output, WIDTH, read data; registered.
- rdvalid, output, 1, rddata updated this cycle (pulse).
- empty, output, 1, count == 0.
- almost_empty, output, 1, count <= AE_LEVEL.
- count, output, log2(DEPTH)+1, current occupancy, 0..DEPTH.
- err_clr, input, 1, clears sticky error flags (SYNC_FIFO_ERR_EN only).
- overflow, output, 1, sticky: write attempted while full (SYNC_FIFO_ERR_EN only).
- underflow, output, 1, sticky: read attempted while empty (SYNC_FIFO_ERR_EN only).

Behaviour:
- Reset (asrst high, asynchronous): wrptr=0, rdptr=0, count=0, rddata=0, rdvalid=0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not reset.
- Storage is a register array of DEPTH x WIDTH. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accepted write: wr_ok = wren && (!full || rd_ok). On wr_ok: mem[wrptr] <= wrdata, wrptr += 1.
- Accepted read: rd_ok = rden && !empty. On rd_ok: rddata <= mem[rdptr], rdptr += 1, rdvalid <= 1. Otherwise rdvalid <= 0 and rddata holds.
- Read latency: 1 cycle; data appears on rddata with rdvalid the cycle after the accepting edge.
- Count update: +1 when only wr_ok; -1 when only rd_ok; unchanged when both or neither.
- Simultaneous read+write while full: both accepted, count stays DEPTH, and the read returns the oldest entry, not wrdata.
- Simultaneous read+write while empty: write accepted, read rejected, count becomes 1, rdvalid=0.
- Read-before-write on the same address (possible only when full) returns the old data.
- Write while full without read: dropped, no state change. Read while empty: rejected, rddata holds.
- Flags full, empty, almost_full and almost_empty decode from the registered count. They are valid the cycle after the count changes; no combinational path from wren/rden.
- Reset mid-operation: all pointers, count and flags return to reset values immediately. Data in flight is discarded.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- Defined:
  - overflow sets on a cycle with wren && full && !rd_ok.
  - underflow sets on a cycle with rden && empty.
  - Both are sticky until err_clr=1 at a clock edge. If set and clear coincide, set wins.
- Undefined: overflow and underflow tie to 0; err_clr is ignored; no error registers are instantiated.

Test Plan:
All scenarios use DEPTH=8, WIDTH=8, AF_LEVEL=6, AE_LEVEL=2.
1. Reset, then write 0x01..0x08 on 8 cycles:
   - count steps 1..8.
   - almost_empty drops when count=3; almost_full rises when count=6; full=1 when count=8.
   - A 9th write of 0xFF is dropped, count stays 8, overflow=1 if enabled.
2. From full, read 8 cycles:
   - rddata is 0x01..0x08, each with rdvalid one cycle after its rden.
   - empty=1 at the end; a further rden gives rdvalid=0, rddata holds 0x08, underflow=1 if enabled.
3. Full FIFO, wren+rden same cycle with wrdata 0xAA: rddata=0x01, count stays 8. After draining, 0xAA is the last word out.
4. Empty FIFO, wren+rden same cycle with 0x55: count=1, rdvalid=0. The next read returns 0x55.
5. Wrap-around: 20 cycles of continuous write+read with a steady count of 3; output sequence matches input order across the pointer wrap.
6. Assert asrst while count=5 mid-burst: count=0, empty=1, rdvalid=0 immediately. Then pulse err_clr: error flags return to 0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with concurrent read/write, a registered
// read port with a one-cycle valid strobe, occupancy count and programmable
// almost-full / almost-empty thresholds.
//
// Optional feature macro: SYNC_FIFO_ERR_EN
//   defined   -> sticky overflow/underflow flags, cleared by err_clr
//   undefined -> overflow/underflow tied low, err_clr ignored
//
// All status flags decode from the registered count, so there is no
// combinational path from wren/rden to any flag.

module sync_fifo_flags #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     asrst,
  input  logic                     wren,
  input  logic [WIDTH-1:0]         wrdata,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rden,
  output logic [WIDTH-1:0]         rddata,
  output logic                     rdvalid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrptr;
  logic [AW-1:0]    rdptr;
  logic             wr_ok;
  logic             rd_ok;

  // Accept decisions; a write into a full FIFO is allowed when a read frees a slot
  always_comb begin
    rd_ok = rden && !empty;
    wr_ok = wren && (!full || rd_ok);
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wrptr] <= wrdata;
    end
  end

  // Write pointer, wraps naturally at DEPTH
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      wrptr <= '0;
    end else if (wr_ok) begin
      wrptr <= wrptr + PTR_ONE;
    end
  end

  // Read pointer, wraps naturally at DEPTH
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      rdptr <= '0;
    end else if (rd_ok) begin
      rdptr <= rdptr + PTR_ONE;
    end
  end

  // Registered read port; reading mem before this edge's write returns old data
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      rddata  <= '0;
      rdvalid <= 1'b0;
    end else begin
      rdvalid <= rd_ok;
      if (rd_ok) begin
        rddata <= mem[rdptr];
      end
    end
  end

  // Occupancy count; simultaneous accepted read and write cancel out
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Status flags from the registered count only
  always_comb begin
    full         = (count == FULL_CNT);
    empty        = (count == '0);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

`ifdef SYNC_FIFO_ERR_EN

  logic ovf_set;
  logic unf_set;

  // Error events: dropped write, or read request against an empty FIFO
  always_comb begin
    ovf_set = wren && full && !rd_ok;
    unf_set = rden && empty;
  end

  // Sticky overflow flag; a set on the same edge as a clear wins
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

  // Sticky underflow flag; a set on the same edge as a clear wins
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      underflow <= 1'b0;
    end else if (unf_set) begin
      underflow <= 1'b1;
    end else if (err_clr) begin
      underflow <= 1'b0;
    end
  end

`else

  logic unused_err_clr;

  // Error reporting compiled out: flags are constant low and err_clr is ignored
  always_comb begin
    overflow       = 1'b0;
    underflow      = 1'b0;
    unused_err_clr = err_clr;
  end

`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags (DEPTH=8, WIDTH=8, AF_LEVEL=6, AE_LEVEL=2).
// A queue-based reference model predicts accepted reads; expected read data is
// pushed into a scoreboard queue and a separate monitor pops it whenever the
// DUT raises rdvalid. Count, flags and error bits are compared every cycle.

module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             asrst;
  logic             wren;
  logic [WIDTH-1:0] wrdata;
  logic             full;
  logic             almost_full;
  logic             rden;
  logic [WIDTH-1:0] rddata;
  logic             rdvalid;
  logic             empty;
  logic             almost_empty;
  logic [3:0]       count;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  sync_fifo_flags #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .asrst(asrst),
    .wren(wren), .wrdata(wrdata), .full(full), .almost_full(almost_full),
    .rden(rden), .rddata(rddata), .rdvalid(rdvalid),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] last_rd = '0;
  bit               exp_rdvalid = 1'b0;
  bit               ovf_m = 1'b0;
  bit               unf_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every status output against what the model says
  task automatic check_output();
    int n;
    n = model_q.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("rdvalid", 32'(rdvalid), 32'(exp_rdvalid));
    check("rddata_hold", 32'(rddata), 32'(last_rd));
    check("overflow", 32'(overflow), 32'(ERR_EN && ovf_m));
    check("underflow", 32'(underflow), 32'(ERR_EN && unf_m));
  endtask

  // One clock of stimulus; model decides acceptance from pre-edge occupancy
  task automatic apply_stimulus(input bit wr, input logic [WIDTH-1:0] wd,
                                input bit rd, input bit clr);
    bit is_full, is_empty, rd_ok, wr_ok, ovf_set, unf_set;
    logic [WIDTH-1:0] word;
    wren    = wr;
    wrdata  = wd;
    rden    = rd;
    err_clr = clr;
    is_full  = (model_q.size() == DEPTH);
    is_empty = (model_q.size() == 0);
    rd_ok    = rd && !is_empty;
    wr_ok    = wr && (!is_full || rd_ok);
    ovf_set  = wr && is_full && !rd_ok;
    unf_set  = rd && is_empty;
    if (rd_ok) begin
      word = model_q.pop_front();
      exp_q.push_back(word);
      last_rd = word;
    end
    if (wr_ok) model_q.push_back(wd);
    exp_rdvalid = rd_ok;
    ovf_m = ovf_set ? 1'b1 : (clr ? 1'b0 : ovf_m);
    unf_m = unf_set ? 1'b1 : (clr ? 1'b0 : unf_m);
    @(posedge clk);
    @(negedge clk);
    wren    = 1'b0;
    rden    = 1'b0;
    err_clr = 1'b0;
    check_output();
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    last_rd     = '0;
    exp_rdvalid = 1'b0;
    ovf_m       = 1'b0;
    unf_m       = 1'b0;
  endtask

  // Monitor: every rdvalid pulse must match the oldest predicted read
  always @(negedge clk) begin
    if (!asrst && rdvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_unexpected actual=%0h expected=none at %0t", rddata, $time);
      end else begin
        check("rd_scoreboard", 32'(rddata), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    asrst = 1'b1; wren = 1'b0; rden = 1'b0; err_clr = 1'b0; wrdata = '0;
    repeat (2) @(negedge clk);
    asrst = 1'b0;
    model_reset();
    check_output();

    $display("[TB] fill 0x01..0x08 then overfill");
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0);

    $display("[TB] drain and underflow");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] read+write while full");
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] read+write while empty");
    apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] wrap-around at steady count 3");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] asynchronous reset mid-burst");
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h11, 1'b1, 1'b0);
    while (model_q.size() < 5) apply_stimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    while (model_q.size() > 5) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    #2;
    asrst = 1'b1;
    #1;
    model_reset();
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_rdvalid", 32'(rdvalid), 32'd0);
    check("reset_rddata", 32'(rddata), 32'd0);
    @(negedge clk);
    asrst = 1'b0;
    check_output();
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
